memory_stage: RTL

//   Y86-64 pipeline memory stage plus the M->W pipeline register. Takes the M-register fields,

---
 rtl/memory_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   Y86-64 pipeline memory stage and the M->W pipeline register.
//   Selects the data-memory address from the M-register fields, performs
//   8-byte little-endian reads and writes against an internal byte-addressed
//   memory, derives m_stat, and registers the write-back fields.
//
// Configuration macro:
//   MISALIGN_CHECK_EN  when defined, any access with addr[2:0] != 0 is a
//                      memory error (m_stat = ADR, write suppressed).
//                      When undefined, unaligned accesses touch addr..addr+7.
//
// Parameters:
//   MEM_BYTES  data memory size in bytes (legal access: addr <= MEM_BYTES-8)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   M_stat, M_icode                 status / instruction code from M register
//   M_valE, M_valA                  address or ALU result / store data
//   M_dstE, M_dstM                  destination registers (F = none)
//   W_stall, W_bubble               W register hold / NOP insertion
//   m_valM, m_stat                  combinational read data and stage status
//   W_stat..W_dstM                  registered write-back fields
// -----------------------------------------------------------------------------
module memory_stage #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_ADR = 3'd3
    } stat_e;

    typedef enum logic [3:0] {
        I_NOP    = 4'h1,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    logic [7:0]    mem [MEM_BYTES];
    logic [63:0]   mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic          misaligned;
    logic          dmem_error;
    logic          mem_we;
    logic          halt_hold;
    logic [AW-1:0] base;

    // Address source and access type from the instruction code
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (M_icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                mem_addr  = M_valE;
                mem_write = 1'b1;
            end
            I_MRMOVQ: begin
                mem_addr = M_valE;
                mem_read = 1'b1;
            end
            I_RET, I_POPQ: begin
                mem_addr = M_valA;
                mem_read = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign misaligned = (mem_addr[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    // Full 64-bit unsigned compare: huge addresses never wrap into range
    assign dmem_error = (mem_read || mem_write) && ((mem_addr > ADDR_MAX) || misaligned);
    assign m_stat     = dmem_error ? STAT_ADR : M_stat;
    assign base       = mem_addr[AW-1:0];
    assign halt_hold  = (W_stat != STAT_AOK);
    assign mem_we     = mem_write && !dmem_error &&
                        (M_stat == STAT_AOK) && (W_stat == STAT_AOK);

    // Little-endian read; base+7 stays in range whenever there is no error
    always_comb begin
        m_valM = '0;
        if (mem_read && !dmem_error) begin
            for (int unsigned i = 0; i < 8; i++) begin
                m_valM[8*i +: 8] = mem[base + AW'(i)];
            end
        end
    end

    // Memory has no reset; a write pending while rst_n is low is dropped
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= M_valA[8*i +: 8];
            end
        end
    end

    // W register: reset > hold (stall or sticky halt) > bubble > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_stat  <= STAT_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= '1;
            W_dstM  <= '1;
        end else if (W_stall || halt_hold) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
        end else if (W_bubble) begin
            W_stat  <= STAT_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= '1;
            W_dstM  <= '1;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
